// File: rtl/rle_stream_packer.sv
// rle_stream_packer: buffers (value, count) runs from the A and D RLE channels
// in two small FIFOs and serializes them round-robin into 3-byte framed records
// (HDR, VAL, CNT) on a valid/ready byte stream.
module rle_stream_packer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [7:0] a_value,
    input  logic [7:0] a_count,
    input  logic       d_valid,
    input  logic [7:0] d_value,
    input  logic [7:0] d_count,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       a_overflow,
    output logic       d_overflow
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] OccFull = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StHdr, StVal, StCnt} state_e;

    // Channel index 0 is A, 1 is D throughout.
    logic [1:0]    in_req;
    logic [15:0]   in_data [2];
    logic [15:0]   mem_q [2][FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q [2];
    logic [AW-1:0] rd_ptr_q [2];
    logic [CW-1:0] occ_q [2];
    logic [1:0]    full;
    logic [1:0]    nonempty;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    ovf_q;

    state_e         state_q, state_d;
    logic [15:0]    hold_q, hold_d;
    logic           ch_q, ch_d;
    logic           last_ch_q, last_ch_d;
    logic [1:0][5:0] seq_q, seq_d;
    logic           any_ne;
    logic           sel_ch;
    logic           take;

    // Zero-length runs carry no data and are silently ignored.
    assign in_req     = {d_valid && (d_count != 8'd0), a_valid && (a_count != 8'd0)};
    assign in_data[0] = {a_value, a_count};
    assign in_data[1] = {d_value, d_count};

    // FIFO status and push qualification
    always_comb begin
        full     = '0;
        nonempty = '0;
        push     = '0;
        for (int c = 0; c < 2; c++) begin
            full[c]     = (occ_q[c] == OccFull);
            nonempty[c] = (occ_q[c] != '0);
            // Full is judged on current occupancy, so a same-cycle pop does not make room.
            push[c]     = in_req[c] && !full[c];
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= in_data[c];
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                occ_q[c]    <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    wr_ptr_q[c] <= wr_ptr_q[c] + AW'(1);
                end
                if (pop[c]) begin
                    rd_ptr_q[c] <= rd_ptr_q[c] + AW'(1);
                end
                if (push[c] && !pop[c]) begin
                    occ_q[c] <= occ_q[c] + CW'(1);
                end else if (!push[c] && pop[c]) begin
                    occ_q[c] <= occ_q[c] - CW'(1);
                end
                if (in_req[c] && full[c]) begin
                    ovf_q[c] <= 1'b1;
                end
            end
        end
    end

    // Round-robin: on a tie take the channel not served last.
    assign any_ne = |nonempty;
    assign sel_ch = nonempty[1] && (!nonempty[0] || !last_ch_q);

    // Serializer next-state, head pop and sequence numbering
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        ch_d      = ch_q;
        last_ch_d = last_ch_q;
        seq_d     = seq_q;
        pop       = '0;
        take      = 1'b0;
        unique case (state_q)
            StIdle: take = any_ne;
            StHdr:  if (out_ready) state_d = StVal;
            StVal:  if (out_ready) state_d = StCnt;
            StCnt: begin
                if (out_ready) begin
                    seq_d[ch_q] = seq_q[ch_q] + 6'd1;
                    take        = any_ne;
                    if (!any_ne) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (take) begin
            pop[sel_ch] = 1'b1;
            hold_d      = mem_q[sel_ch][rd_ptr_q[sel_ch]];
            ch_d        = sel_ch;
            last_ch_d   = sel_ch;
            state_d     = StHdr;
        end
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            ch_q      <= 1'b0;
            last_ch_q <= 1'b1;
            seq_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            ch_q      <= ch_d;
            last_ch_q <= last_ch_d;
            seq_q     <= seq_d;
        end
    end

    // Byte decode from state and holding register; stable while stalled
    always_comb begin
        out_valid = (state_q != StIdle);
        out_last  = (state_q == StCnt);
        out_data  = '0;
        unique case (state_q)
            StIdle:  out_data = '0;
            StHdr:   out_data = {1'b1, ch_q, seq_q[ch_q]};
            StVal:   out_data = hold_q[15:8];
            StCnt:   out_data = hold_q[7:0];
            default: out_data = '0;
        endcase
    end

    assign a_overflow = ovf_q[0];
    assign d_overflow = ovf_q[1];
endmodule

// File: tb/tb_rle_stream_packer.sv
// Self-checking bench for rle_stream_packer: a byte-queue reference model is
// compared every cycle, plus literal checks of the directed scenarios.
module tb_rle_stream_packer;
    localparam int Depth = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, d_valid, out_ready;
    logic [7:0] a_value, a_count, d_value, d_count;
    logic       out_valid, out_last, a_overflow, d_overflow;
    logic [7:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rle_stream_packer #(.FIFO_DEPTH(Depth)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_value(a_value), .a_count(a_count),
        .d_valid(d_valid), .d_value(d_value), .d_count(d_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .a_overflow(a_overflow), .d_overflow(d_overflow)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as queues, the record on the wire as a byte queue.
    logic [15:0] fqa[$];
    logic [15:0] fqd[$];
    logic [7:0]  rec[$];
    logic [5:0]  m_seq [2];
    bit          m_last, m_ch;
    bit [1:0]    m_ovf;
    bit          started = 1'b0;
    logic [8:0]  log_q[$];

    always @(posedge clk) begin
        int na, nd;
        bit take, ch;
        logic [15:0] e;
        if (rst) begin
            fqa.delete(); fqd.delete(); rec.delete();
            m_seq[0] = '0; m_seq[1] = '0;
            m_last = 1'b1; m_ch = 1'b0; m_ovf = '0;
            started = 1'b1;
        end else begin
            na = fqa.size();
            nd = fqd.size();
            take = 1'b0;
            if (rec.size() == 0) begin
                take = 1'b1;
            end else if (out_ready) begin
                if (rec.size() == 1) begin
                    m_seq[m_ch] = m_seq[m_ch] + 6'd1;
                    take = 1'b1;
                end
                void'(rec.pop_front());
            end
            if (take && (na != 0 || nd != 0)) begin
                ch = (na == 0) ? 1'b1 : (nd == 0) ? 1'b0 : ~m_last;
                e = ch ? fqd.pop_front() : fqa.pop_front();
                m_ch = ch;
                m_last = ch;
                rec.push_back({1'b1, ch, m_seq[ch]});
                rec.push_back(e[15:8]);
                rec.push_back(e[7:0]);
            end
            if (a_valid && a_count != 8'd0) begin
                if (na == Depth) m_ovf[0] = 1'b1;
                else fqa.push_back({a_value, a_count});
            end
            if (d_valid && d_count != 8'd0) begin
                if (nd == Depth) m_ovf[1] = 1'b1;
                else fqd.push_back({d_value, d_count});
            end
        end
    end

    // Compare process: inputs change just after posedge, so at negedge everything
    // seen applies to the coming edge.
    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 16'(out_valid), 16'(rec.size() != 0));
            if (rec.size() != 0) begin
                check("out_data", 16'(out_data), 16'(rec[0]));
                check("out_last", 16'(out_last), 16'(rec.size() == 1));
            end
            check("a_overflow", 16'(a_overflow), 16'(m_ovf[0]));
            check("d_overflow", 16'(d_overflow), 16'(m_ovf[1]));
            if (out_valid && out_ready) log_q.push_back({out_last, out_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit av, input logic [7:0] aval, input logic [7:0] acnt,
                         input bit dv, input logic [7:0] dval, input logic [7:0] dcnt);
        a_valid = av; a_value = aval; a_count = acnt;
        d_valid = dv; d_value = dval; d_count = dcnt;
        tick();
        a_valid = 1'b0;
        d_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_valid = 1'b0; d_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rst out_valid", 16'(out_valid), 16'h0);
        check("rst out_data", 16'(out_data), 16'h0);
        check("rst out_last", 16'(out_last), 16'h0);
        check("rst overflow", 16'({a_overflow, d_overflow}), 16'h0);
        log_q.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    initial begin
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b1; out_ready = 1'b1;
        a_valid = 1'b0; a_value = '0; a_count = '0;
        d_valid = 1'b0; d_value = '0; d_count = '0;
        wait_cycles(2);
        do_reset();

        // Single run, latency and framing
        drive(1, 8'hFD, 8'h05, 0, 8'h00, 8'h00);
        check("lat not yet", 16'(out_valid), 16'h0);
        tick();
        check("lat hdr valid", 16'(out_valid), 16'h1);
        check("lat hdr data", 16'(out_data), 16'h80);
        wait_cycles(6);
        check("single len", 16'(log_q.size()), 16'd3);
        if (log_q.size() == 3) begin
            check("single hdr", 16'(log_q[0]), 16'h080);
            check("single val", 16'(log_q[1]), 16'h0FD);
            check("single cnt", 16'(log_q[2]), 16'h105);
        end
        check("single idle", 16'(out_valid), 16'h0);

        // Simultaneous A and D, then a second tie goes back to A
        do_reset();
        drive(1, 8'h10, 8'h02, 1, 8'h00, 8'h09);
        wait_cycles(10);
        drive(1, 8'h11, 8'h03, 1, 8'h01, 8'h04);
        wait_cycles(10);
        check("tie len", 16'(log_q.size()), 16'd12);
        if (log_q.size() == 12) begin
            check("tie a hdr", 16'(log_q[0]), 16'h080);
            check("tie a val", 16'(log_q[1]), 16'h010);
            check("tie a cnt", 16'(log_q[2]), 16'h102);
            check("tie d hdr", 16'(log_q[3]), 16'h0C0);
            check("tie d val", 16'(log_q[4]), 16'h000);
            check("tie d cnt", 16'(log_q[5]), 16'h109);
            check("tie2 a hdr", 16'(log_q[6]), 16'h081);
            check("tie2 d hdr", 16'(log_q[9]), 16'h0C1);
        end

        // Backpressure
        do_reset();
        drive(1, 8'h7F, 8'h33, 0, 8'h00, 8'h00);
        for (int i = 0; i < 16; i++) begin
            out_ready = pat[i % 4];
            tick();
        end
        out_ready = 1'b1;
        wait_cycles(4);
        check("bp len", 16'(log_q.size()), 16'd3);
        if (log_q.size() == 3) begin
            check("bp hdr", 16'(log_q[0]), 16'h080);
            check("bp val", 16'(log_q[1]), 16'h07F);
            check("bp cnt", 16'(log_q[2]), 16'h133);
        end

        // Overflow: hold register plus four FIFO slots, sixth run dropped
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) drive(1, 8'(8'h20 + i), 8'(i), 0, 8'h00, 8'h00);
        check("ovf a", 16'(a_overflow), 16'h1);
        check("ovf d", 16'(d_overflow), 16'h0);
        out_ready = 1'b1;
        wait_cycles(20);
        check("ovf len", 16'(log_q.size()), 16'd15);
        if (log_q.size() == 15) begin
            for (int k = 0; k < 5; k++) begin
                check("ovf hdr", 16'(log_q[3 * k]), 16'(9'h080 + k));
                check("ovf cnt", 16'(log_q[3 * k + 2]), 16'(9'h101 + k));
            end
        end
        check("ovf a sticky", 16'(a_overflow), 16'h1);

        // Sequence wrap on A, D unaffected
        do_reset();
        for (int k = 0; k < 65; k++) begin
            drive(1, 8'(k), 8'h01, 0, 8'h00, 8'h00);
            wait_cycles(2);
        end
        drive(0, 8'h00, 8'h00, 1, 8'h44, 8'h02);
        wait_cycles(8);
        check("wrap len", 16'(log_q.size()), 16'd198);
        if (log_q.size() == 198) begin
            check("wrap hdr63", 16'(log_q[189]), 16'h0BF);
            check("wrap hdr64", 16'(log_q[192]), 16'h080);
            check("wrap d hdr", 16'(log_q[195]), 16'h0C0);
        end
        check("wrap no ovf", 16'(a_overflow), 16'h0);

        // Reset with VAL pending and two runs queued
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) drive(1, 8'(8'h10 * i), 8'(i), 0, 8'h00, 8'h00);
        drive(0, 8'h00, 8'h00, 1, 8'h00, 8'h00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mid val pending", 16'(out_data), 16'h10);
        rst = 1'b1;
        tick();
        check("mid rst valid", 16'(out_valid), 16'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        log_q.delete();
        wait_cycles(8);
        check("mid stale", 16'(log_q.size()), 16'd0);
        check("mid ovf", 16'({a_overflow, d_overflow}), 16'h0);
        drive(1, 8'h55, 8'h07, 0, 8'h00, 8'h00);
        wait_cycles(6);
        check("mid new len", 16'(log_q.size()), 16'd3);
        if (log_q.size() != 0) check("mid new hdr", 16'(log_q[0]), 16'h080);

        // Randomized traffic, model checks every cycle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 699) == 0);
            a_valid   = ($urandom_range(0, 3) == 0);
            a_value   = 8'($urandom);
            a_count   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            d_valid   = ($urandom_range(0, 3) == 0);
            d_value   = 8'($urandom);
            d_count   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0; a_valid = 1'b0; d_valid = 1'b0; out_ready = 1'b1;
        wait_cycles(40);
        check("drain idle", 16'(out_valid), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
